// File: rtl/i2c_controller.sv
// Single-master I2C controller: START, 7-bit address + R/W, one data byte, STOP on open-drain lines.
// Define I2C_CTRL_CLOCK_STRETCH_EN to let a target hold SCL low and stall the quarter counter.
module i2c_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       done,
  output logic       nack,
  output logic       busy,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_oe
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_t;

  state_t r_state, w_next;

  logic [DW-1:0] r_div;
  logic [1:0]    r_quarter;
  logic [2:0]    r_bit;
  logic [7:0]    r_txShift, r_rxShift, r_wdata, r_rdata;
  logic          r_rw, r_nack, r_done, r_rdataValid;
  logic          w_stall, w_qEnd, w_phaseEnd, w_bitPhase, w_sample;

  // A stretched SCL only matters while the controller has released it (q2-q3).
`ifdef I2C_CTRL_CLOCK_STRETCH_EN
  assign w_stall = (r_state != S_IDLE) && r_quarter[1] && !scl_oe && !scl_i;
`else
  logic w_unusedScl;
  assign w_unusedScl = scl_i;
  assign w_stall     = 1'b0;
`endif

  assign w_qEnd     = !w_stall && (r_div == DIV_LAST);
  assign w_phaseEnd = w_qEnd && (r_quarter == 2'd3);
  assign w_bitPhase = (r_state == S_ADDR) || (r_state == S_AACK) ||
                      (r_state == S_DATA) || (r_state == S_DACK);
  assign w_sample   = w_bitPhase && (r_quarter == 2'd3) && (r_div == '0) && !w_stall;

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = !cmd_ready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdataValid;
  assign done        = r_done;
  assign nack        = r_nack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_START;
      S_START: begin
        sda_oe = r_quarter[1];
        if (w_phaseEnd) w_next = S_ADDR;
      end
      S_ADDR: begin
        scl_oe = !r_quarter[1];
        sda_oe = !r_txShift[7];
        if (w_phaseEnd && r_bit == 3'd7) w_next = S_AACK;
      end
      S_AACK: begin
        scl_oe = !r_quarter[1];
        if (w_phaseEnd) w_next = r_nack ? S_STOP : S_DATA;
      end
      S_DATA: begin
        scl_oe = !r_quarter[1];
        sda_oe = !r_rw && !r_txShift[7];
        if (w_phaseEnd && r_bit == 3'd7) w_next = S_DACK;
      end
      S_DACK: begin
        scl_oe = !r_quarter[1];
        if (w_phaseEnd) w_next = S_STOP;
      end
      S_STOP: begin
        scl_oe = (r_quarter == 2'd0);
        sda_oe = !r_quarter[1];
        if (w_phaseEnd) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 3'd0;
    end else if (r_state == S_IDLE) begin
      r_div     <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 3'd0;
    end else if (!w_stall) begin
      if (w_qEnd) begin
        r_div     <= '0;
        r_quarter <= r_quarter + 2'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_phaseEnd)
        r_bit <= ((r_state == S_ADDR) || (r_state == S_DATA)) ? r_bit + 3'd1 : 3'd0;
    end
  end

  // Shift registers advance at phase boundaries so SDA only changes at the start of q0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txShift    <= 8'h00;
      r_rxShift    <= 8'h00;
      r_wdata      <= 8'h00;
      r_rdata      <= 8'h00;
      r_rw         <= 1'b0;
      r_nack       <= 1'b0;
      r_done       <= 1'b0;
      r_rdataValid <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_rdataValid <= 1'b0;
      if (r_state == S_IDLE && cmd_valid) begin
        r_txShift <= {cmd_addr, cmd_rw};
        r_rw      <= cmd_rw;
        r_wdata   <= cmd_wdata;
        r_nack    <= 1'b0;
      end
      if (w_sample) begin
        case (r_state)
          S_AACK:  if (sda_i) r_nack <= 1'b1;
          S_DATA:  if (r_rw) r_rxShift <= {r_rxShift[6:0], sda_i};
          S_DACK:  if (!r_rw && sda_i) r_nack <= 1'b1;
          default: ;
        endcase
      end
      if (w_phaseEnd) begin
        case (r_state)
          S_ADDR:  r_txShift <= (r_bit == 3'd7) ? r_wdata : {r_txShift[6:0], 1'b0};
          S_DATA:  r_txShift <= {r_txShift[6:0], 1'b0};
          S_STOP: begin
            r_done <= 1'b1;
            if (r_rw && !r_nack) begin
              r_rdataValid <= 1'b1;
              r_rdata      <= r_rxShift;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Self-checking bench for i2c_controller: open-drain bus with a simple target model and a
// scoreboard of expected transaction results.
module tb_i2c_controller;

  localparam int CLK_DIV     = 4;
  localparam int FULL_CYCLES = 80 * CLK_DIV + 1;
  localparam int NACK_CYCLES = 44 * CLK_DIV + 1;

  typedef struct {
    int          cycles;
    logic        nack;
    logic        rv;
    logic [7:0]  rdata;
    int          nBits;
    logic [17:0] bits;
  } exp_t;

  exp_t expQ[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       done;
  logic       nack;
  logic       busy;
  logic       scl_i;
  logic       scl_oe;
  logic       sda_i;
  logic       sda_oe;

  logic slaveDrive = 1'b0;
  logic stretchLow = 1'b0;
  assign scl_i = !scl_oe && !stretchLow;
  assign sda_i = !sda_oe && !slaveDrive;

  int checkCount = 0;
  int passCount  = 0;

  // Target model state
  logic [6:0] devAddr   = 7'h2A;
  bit         respond   = 1'b1;
  logic [7:0] readByte  = 8'h67;
  int         bitCnt    = 0;
  logic [7:0] addrByte  = 8'h00;
  logic [7:0] dataByte  = 8'h00;
  bit         acked     = 1'b0;
  bit         active    = 1'b0;
  bit         sawStop   = 1'b0;
  bit         pendBit   = 1'b0;
  bit         pendValid = 1'b0;
  bit         stretchArm = 1'b0;
  int         stretchCnt = 0;
  logic       prevScl   = 1'b1;
  logic       prevSda   = 1'b1;
  logic       curScl, curSda;
  bit         busBits[$];

  always #5 clk = ~clk;

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_rw      (cmd_rw),
    .cmd_wdata   (cmd_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .nack        (nack),
    .busy        (busy),
    .scl_i       (scl_i),
    .scl_oe      (scl_oe),
    .sda_i       (sda_i),
    .sda_oe      (sda_oe)
  );

  // Target: decodes START/STOP, logs each clocked SDA bit, ACKs its address and drives read data.
  always @(negedge clk) begin
    curScl = scl_i;
    curSda = sda_i;
    if (prevScl && curScl && prevSda && !curSda) begin
      active = 1'b1; bitCnt = 0; acked = 1'b0; slaveDrive = 1'b0; pendValid = 1'b0;
      busBits.delete();
    end else if (prevScl && curScl && !prevSda && curSda) begin
      active = 1'b0; slaveDrive = 1'b0; pendValid = 1'b0; sawStop = 1'b1;
    end else if (active && !prevScl && curScl) begin
      pendBit = curSda; pendValid = 1'b1;
      if (bitCnt < 8) addrByte = {addrByte[6:0], curSda};
      else if (bitCnt >= 9 && bitCnt < 17) dataByte = {dataByte[6:0], curSda};
      bitCnt++;
    end else if (active && prevScl && !curScl) begin
      if (pendValid) busBits.push_back(pendBit);
      pendValid  = 1'b0;
      slaveDrive = 1'b0;
      if (bitCnt == 8 && respond && addrByte[7:1] == devAddr) begin
        slaveDrive = 1'b1; acked = 1'b1;
      end else if (bitCnt >= 9 && bitCnt < 17 && acked && addrByte[0]) begin
        slaveDrive = !readByte[16 - bitCnt];
      end else if (bitCnt == 17 && acked && !addrByte[0]) begin
        slaveDrive = 1'b1;
      end
      if (bitCnt == 8 && stretchArm) begin
        stretchLow = 1'b1; stretchArm = 1'b0; stretchCnt = 0;
      end
    end
    if (stretchLow && !scl_oe) begin
      if (stretchCnt == 10) stretchLow = 1'b0;
      else stretchCnt++;
    end
    prevScl = curScl;
    prevSda = curSda;
  end

  function automatic logic [17:0] packBits();
    logic [17:0] v = '0;
    foreach (busBits[i]) v = {v[16:0], busBits[i]};
    return v;
  endfunction

  task automatic startCmd(input logic [6:0] a, input logic r, input logic [7:0] w);
    cmd_addr  = a;
    cmd_rw    = r;
    cmd_wdata = w;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output bit timedOut);
    cycles   = 1;
    timedOut = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkCount++; if (scl_oe !== 1'b0) $display("[TB] FAIL reset_scl_oe: got %b expected 0", scl_oe); else passCount++;
    checkCount++; if (sda_oe !== 1'b0) $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
    checkCount++; if (rdata_valid !== 1'b0) $display("[TB] FAIL reset_rdata_valid: got %b expected 0", rdata_valid); else passCount++;
    checkCount++; if (nack !== 1'b0) $display("[TB] FAIL reset_nack: got %b expected 0", nack); else passCount++;
    checkCount++; if (rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); else passCount++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    exp_t e; int cyc; bit to;
    respond = 1'b1;
    expQ.push_back('{cycles: FULL_CYCLES, nack: 1'b0, rv: 1'b0, rdata: 8'h00, nBits: 18,
                     bits: {8'h54, 1'b0, 8'hA5, 1'b0}});
    startCmd(7'h2A, 1'b0, 8'hA5);
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL write_busy_rise: got %b expected 1", busy); else passCount++;
    checkCount++; if (cmd_ready !== 1'b0) $display("[TB] FAIL write_ready_low: got %b expected 0", cmd_ready); else passCount++;
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL write_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL write_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL write_nack: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (rdata_valid !== e.rv) $display("[TB] FAIL write_rdata_valid: got %b expected %b", rdata_valid, e.rv); else passCount++;
    checkCount++; if (rdata !== e.rdata) $display("[TB] FAIL write_rdata_hold: got %h expected %h", rdata, e.rdata); else passCount++;
    checkCount++; if (busBits.size() != e.nBits) $display("[TB] FAIL write_bit_count: got %0d expected %0d", busBits.size(), e.nBits); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL write_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
    checkCount++; if (dataByte !== 8'hA5) $display("[TB] FAIL write_target_data: got %h expected a5", dataByte); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL write_done_ready: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy); else passCount++;
    @(posedge clk); #1;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL write_done_pulse: got %b expected 0", done); else passCount++;
  endtask

  task automatic test_read();
    exp_t e; int cyc; bit to;
    respond = 1'b1; readByte = 8'h67;
    expQ.push_back('{cycles: FULL_CYCLES, nack: 1'b0, rv: 1'b1, rdata: 8'h67, nBits: 18,
                     bits: {8'h55, 1'b0, 8'h67, 1'b1}});
    startCmd(7'h2A, 1'b1, 8'h00);
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL read_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL read_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (rdata_valid !== e.rv) $display("[TB] FAIL read_rdata_valid: got %b expected %b", rdata_valid, e.rv); else passCount++;
    checkCount++; if (rdata !== e.rdata) $display("[TB] FAIL read_rdata: got %h expected %h", rdata, e.rdata); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL read_nack: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (busBits.size() != e.nBits) $display("[TB] FAIL read_bit_count: got %0d expected %0d", busBits.size(), e.nBits); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL read_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
    @(posedge clk); #1;
    checkCount++; if (rdata_valid !== 1'b0 || done !== 1'b0) $display("[TB] FAIL read_pulse_width: got rv=%b done=%b expected 0 0", rdata_valid, done); else passCount++;
    checkCount++; if (rdata !== 8'h67) $display("[TB] FAIL read_rdata_hold: got %h expected 67", rdata); else passCount++;
  endtask

  task automatic test_addr_nack();
    exp_t e; int cyc; bit to;
    respond = 1'b0; sawStop = 1'b0;
    expQ.push_back('{cycles: NACK_CYCLES, nack: 1'b1, rv: 1'b0, rdata: 8'h67, nBits: 9,
                     bits: 18'({8'h55, 1'b1})});
    startCmd(7'h2A, 1'b1, 8'h00);
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL nack_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL nack_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL nack_flag: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (rdata_valid !== e.rv) $display("[TB] FAIL nack_rdata_valid: got %b expected %b", rdata_valid, e.rv); else passCount++;
    checkCount++; if (rdata !== e.rdata) $display("[TB] FAIL nack_rdata_hold: got %h expected %h", rdata, e.rdata); else passCount++;
    checkCount++; if (busBits.size() != e.nBits) $display("[TB] FAIL nack_bit_count: got %0d expected %0d", busBits.size(), e.nBits); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL nack_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
    checkCount++; if (sawStop !== 1'b1) $display("[TB] FAIL nack_stop_seen: got %b expected 1", sawStop); else passCount++;
    respond = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc; bit to;
    respond = 1'b1;
    expQ.push_back('{cycles: FULL_CYCLES, nack: 1'b0, rv: 1'b0, rdata: 8'h67, nBits: 18,
                     bits: {8'h54, 1'b0, 8'h3C, 1'b0}});
    cmd_addr = 7'h2A; cmd_rw = 1'b0; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_addr = 7'h11; cmd_wdata = 8'hFF;
    checkCount++; if (cmd_ready !== 1'b0) $display("[TB] FAIL hold_ready_low: got %b expected 0", cmd_ready); else passCount++;
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL hold_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL hold_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL hold_nack_cleared: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL hold_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
    checkCount++; if (dataByte !== 8'h3C) $display("[TB] FAIL hold_target_data: got %h expected 3c", dataByte); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL hold_ready_in_done: got %b expected 1", cmd_ready); else passCount++;
    expQ.push_back('{cycles: NACK_CYCLES, nack: 1'b1, rv: 1'b0, rdata: 8'h67, nBits: 9,
                     bits: 18'({8'h22, 1'b1})});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL hold_accept_in_done: got busy=%b expected 1", busy); else passCount++;
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL second_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL second_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL second_nack: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL second_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
  endtask

`ifdef I2C_CTRL_CLOCK_STRETCH_EN
  task automatic test_stretch();
    exp_t e; int cyc; bit to;
    respond = 1'b1; stretchArm = 1'b1;
    expQ.push_back('{cycles: FULL_CYCLES + 10, nack: 1'b0, rv: 1'b0, rdata: 8'h67, nBits: 18,
                     bits: {8'h54, 1'b0, 8'hA5, 1'b0}});
    startCmd(7'h2A, 1'b0, 8'hA5);
    waitDone(cyc, to);
    e = expQ.pop_front();
    checkCount++; if (to) $display("[TB] FAIL stretch_timeout: got no done expected done"); else passCount++;
    checkCount++; if (cyc != e.cycles) $display("[TB] FAIL stretch_latency: got %0d expected %0d", cyc, e.cycles); else passCount++;
    checkCount++; if (nack !== e.nack) $display("[TB] FAIL stretch_nack: got %b expected %b", nack, e.nack); else passCount++;
    checkCount++; if (packBits() !== e.bits) $display("[TB] FAIL stretch_bus_bits: got %b expected %b", packBits(), e.bits); else passCount++;
    checkCount++; if (dataByte !== 8'hA5) $display("[TB] FAIL stretch_target_data: got %h expected a5", dataByte); else passCount++;
  endtask
`endif

  task automatic test_reset_mid();
    bit found = 1'b0;
    int doneSeen = 0;
    respond = 1'b1;
    startCmd(7'h2A, 1'b0, 8'h5A);
    for (int i = 0; i < 2000; i++) begin
      if (bitCnt == 14 && scl_oe === 1'b1 && sda_oe === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkCount++; if (!found) $display("[TB] FAIL rstmid_reach_data: got not reached expected DATA phase"); else passCount++;
    reset = 1'b0;
    #1;
    checkCount++; if (scl_oe !== 1'b0) $display("[TB] FAIL rstmid_scl_oe: got %b expected 0", scl_oe); else passCount++;
    checkCount++; if (sda_oe !== 1'b0) $display("[TB] FAIL rstmid_sda_oe: got %b expected 0", sda_oe); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passCount++;
    #1;
    reset = 1'b1;
    #1;
    checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b expected 1", cmd_ready); else passCount++;
    repeat (400) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    checkCount++; if (doneSeen != 0) $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", doneSeen); else passCount++;
    checkCount++; if (rdata !== 8'h00) $display("[TB] FAIL rstmid_rdata: got %h expected 00", rdata); else passCount++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
`ifdef I2C_CTRL_CLOCK_STRETCH_EN
    test_stretch();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
